// File: rtl/lfsr_sched.sv
// 8-bit right-shift LFSR with button/prescaler/arbiter step sources and seed reload.
// Optional LFSR_SCHED_STEP_COUNT_EN adds a 16-bit applied-step counter output.
module lfsr_sched #(
  parameter int unsigned PRESCALE = 5000000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        run_en,
  input  logic        seed_load,
  input  logic [7:0]  seed,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [7:0]  rand_out,
  output logic [7:0]  random_num,
  output logic        busy
`ifdef LFSR_SCHED_STEP_COUNT_EN
  ,
  output logic [15:0] step_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, GNT, GAP} state_t;

  state_t           state, state_nxt;
  logic             winner, winner_nxt;
  logic             rr_last;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             step;
  logic             fb;

  assign tick = run_en && (cnt == CNT_W'(PRESCALE - 1));
  // All sources collapse to one step; a seed load overrides them.
  assign step = (btn_step || tick || (state == GNT)) && !seed_load;
  assign fb   = random_num[0] ^ random_num[2] ^ random_num[3] ^ random_num[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (seed_load || !run_en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_num <= 8'h01;
    end else if (seed_load) begin
      random_num <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      random_num <= {fb, random_num[7:1]};
    end
  end

`ifdef LFSR_SCHED_STEP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (seed_load) begin
      step_cnt <= '0;
    end else if (step) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      winner  <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
      if (state == GNT) begin
        rr_last <= winner;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    unique case (state)
      IDLE: begin
        if ((req != 2'b00) && !seed_load) begin
          state_nxt  = GNT;
          winner_nxt = (req == 2'b11) ? ~rr_last : req[1];
        end
      end
      GNT:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt      = 2'b00;
    rand_out = '0;
    busy     = (state != IDLE);
    if (state == GNT) begin
      gnt[winner] = 1'b1;
      rand_out    = random_num;
    end
  end

endmodule

// File: doc/lfsr_sched.md
Name: lfsr_sched

Overview:
Self-contained scheduler around the 8-bit right-shift LFSR used on the NVBoard demos. It holds the LFSR state and decides when the state advances. The state can be stepped by a button pulse, stepped automatically by a prescaler, reseeded, or shared between two requesters through a round-robin request/grant port. Each grant consumes exactly one value. Sits between board inputs/consumers and the hex display path, which reads random_num.

Parameters:
PRESCALE, 5000000, clk cycles per auto-step while run_en=1 (legal range 2..2^24-1).
CNT_W, 24, prescaler counter width; must hold PRESCALE-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
btn_step  input  1  single-cycle step pulse (already synchronised/debounced).
run_en  input  1  level; enables prescaler auto-stepping.
seed_load  input  1  single-cycle pulse; load seed.
seed  input  8  seed value, sampled when seed_load=1.
req  input  2  requester i holds req[i] high until it sees gnt[i].
gnt  output  2  one-hot, one-cycle grant pulse.
rand_out  output  8  value handed to the granted requester.
random_num  output  8  current LFSR state (drives display).
busy  output  1  arbiter FSM not in IDLE.

Behaviour:
- Reset (async) values: random_num=8'h01, prescaler count=0, FSM=IDLE, rr_last=1 (so req[0] wins first), gnt=0, rand_out=0, busy=0.
- Step function: fb = r[0]^r[2]^r[3]^r[4]; next = {fb, r[7:1]}.
- Step sources in one cycle: btn_step, prescaler tick, end of a GNT cycle. Any number of simultaneous sources produce a single step, never two.
- seed_load has top priority. random_num <= seed, or 8'h01 if seed==8'h00 (lock-up guard). Any step in the same cycle is suppressed. Prescaler count clears to 0.
- Prescaler: while run_en=1, count increments each cycle. Tick when count==PRESCALE-1; count then wraps to 0. While run_en=0, count is held at 0. The first tick occurs PRESCALE cycles after run_en rises.
- Arbiter FSM has three states: IDLE, GNT, GAP.
  - IDLE: if req!=0 and seed_load=0, pick the winner and go to GNT next cycle. If both requests are high, the winner is the requester that is not rr_last; otherwise it is the single requester.
  - GNT (1 cycle): gnt[winner]=1; rand_out = random_num (combinational during GNT, 0 otherwise). At the closing edge, random_num steps (unless seed_load), rr_last <= winner, and the FSM goes to GAP.
  - GAP (1 cycle): gnt=0, then return to IDLE. This gives a minimum spacing of 3 cycles between grants. A requester that still holds req after its GAP is granted again under the round-robin rules.
- seed_load during GNT: the grant still completes and rand_out shows the pre-load value. The load wins; there is no step.
- Requests that drop before the grant are ignored; there is no speculative grant.
- busy = (FSM != IDLE).
- Reset asserted mid-operation immediately forces all reset values, including dropping gnt.

Optional Feature:
Macro LFSR_SCHED_STEP_COUNT_EN.
- Defined: adds output step_cnt[15:0]. It increments by 1 on every applied step, wraps 16'hFFFF->0, and clears on rst and on seed_load.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then btn_step x2 -> random_num 8'h01 -> 8'h80 -> 8'h40; busy=0, gnt=0 throughout.
- seed_load with seed=8'hA5, then btn_step -> 8'hA5 then 8'h52. seed_load with seed=8'h00 -> random_num=8'h01.
- PRESCALE=4, run_en=1 from state 8'h01 -> steps 4, 8 and 12 cycles after run_en rises (8'h80, 8'h40, 8'h20). run_en=0 -> no further steps, count returns to 0.
- req=2'b11 held from state 8'h01 -> gnt=01 with rand_out=8'h01, then GAP, IDLE, then gnt=10 with rand_out=8'h80. Grants alternate every 3 cycles.
- btn_step coincident with a GNT closing edge -> exactly one step. seed_load coincident with btn_step -> seed loaded, no step.
- Assert rst during GNT -> gnt drops immediately, random_num=8'h01, FSM in IDLE. With LFSR_SCHED_STEP_COUNT_EN defined, step_cnt=0.
